// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared widths and FSM state type for the memory arbiter
package mem_arb_pkg;
  localparam int ADDR_W  = 14;
  localparam int WDATA_W = 16;
  localparam int RDATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with one-hot grant
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);
  // last = 1 means port 1 won most recently, so port 0 is preferred next
  logic last;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (reset) last <= 1'b1;
    else if (accept && (|grant)) last <= grant[1];
  end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin memory arbiter with response timeout
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               p0_req,
  input  logic               p1_req,
  input  logic               p0_we,
  input  logic               p1_we,
  input  logic [ADDR_W-1:0]  p0_addr,
  input  logic [ADDR_W-1:0]  p1_addr,
  input  logic [WDATA_W-1:0] p0_wdata,
  input  logic [WDATA_W-1:0] p1_wdata,
  output logic [RDATA_W-1:0] p0_rdata,
  output logic [RDATA_W-1:0] p1_rdata,
  output logic               p0_done,
  output logic               p1_done,
  output logic               p0_err,
  output logic               p1_err,
  output logic               mem_read_req,
  output logic               mem_write_req,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WDATA_W-1:0] mem_wdata,
  input  logic [RDATA_W-1:0] mem_rdata,
  input  logic               mem_resp,
  output logic               busy
);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       gnt_port;
  logic       we_q;
  logic [1:0] grant;
  logic       accept;

  assign accept = (state == S_IDLE) && (p0_req || p1_req);

  rr_arb2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    ({p1_req, p0_req}),
    .accept (accept),
    .grant  (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      gnt_port      <= 1'b0;
      we_q          <= 1'b0;
      p0_rdata      <= '0;
      p1_rdata      <= '0;
      p0_done       <= 1'b0;
      p1_done       <= 1'b0;
      p0_err        <= 1'b0;
      p1_err        <= 1'b0;
      mem_read_req  <= 1'b0;
      mem_write_req <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
    end else begin
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      p0_err  <= 1'b0;
      p1_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            gnt_port      <= grant[1];
            we_q          <= grant[0] ? p0_we : p1_we;
            mem_addr      <= grant[0] ? p0_addr : p1_addr;
            mem_wdata     <= grant[0] ? p0_wdata : p1_wdata;
            mem_read_req  <= grant[0] ? !p0_we : !p1_we;
            mem_write_req <= grant[0] ? p0_we : p1_we;
            cnt           <= '0;
            busy          <= 1'b1;
            state         <= S_REQ;
          end
        end
        S_REQ: begin
          // a response in the final timeout cycle still counts as success
          if (mem_resp) begin
            mem_read_req  <= 1'b0;
            mem_write_req <= 1'b0;
            if (!we_q) begin
              if (gnt_port) p1_rdata <= mem_rdata;
              else          p0_rdata <= mem_rdata;
            end
            p0_done <= !gnt_port;
            p1_done <= gnt_port;
            state   <= S_DONE;
          end else if (cnt == TO_LAST) begin
            mem_read_req  <= 1'b0;
            mem_write_req <= 1'b0;
            p0_done <= !gnt_port;
            p1_done <= gnt_port;
            p0_err  <= !gnt_port;
            p1_err  <= gnt_port;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p1_req, p0_we, p1_we;
  logic [13:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic [7:0]  p0_rdata, p1_rdata;
  logic        p0_done, p1_done, p0_err, p1_err;
  logic        mem_read_req, mem_write_req;
  logic [13:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_resp;
  logic        busy;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.TIMEOUT_CYC(15)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata), .p0_done(p0_done), .p1_done(p1_done),
    .p0_err(p0_err), .p1_err(p1_err),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_r0, exp_r1;
    int         strobes;
    int         exp_port;
    bit         seen_done;

    reset = 1'b1;
    p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    mem_rdata = '0; mem_resp = 0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_rd", mem_read_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_p0_rdata", p0_rdata, 0);
    reset = 1'b0;
    step();

    // p0 read, response 3 cycles after strobe
    p0_req = 1; p0_we = 0; p0_addr = 14'h0123;
    step();
    chk("rd_strobe", mem_read_req, 1);
    chk("rd_wr_low", mem_write_req, 0);
    chk("rd_busy", busy, 1);
    chk("rd_addr_c1", mem_addr, 14'h0123);
    step();
    chk("rd_addr_c2", mem_addr, 14'h0123);
    step();
    step();
    chk("rd_strobe_c4", mem_read_req, 1);
    mem_resp = 1; mem_rdata = 8'hA5;
    step();
    mem_resp = 0; mem_rdata = 8'h00;
    chk("rd_strobe_off", mem_read_req, 0);
    chk("rd_done", p0_done, 1);
    chk("rd_err", p0_err, 0);
    chk("rd_rdata", p0_rdata, 8'hA5);
    chk("rd_p1_done", p1_done, 0);
    p0_req = 0;
    step();
    chk("rd_done_1cyc", p0_done, 0);
    chk("rd_idle_busy", busy, 0);
    exp_r0 = 8'hA5; exp_r1 = 8'h00;

    // p1 write to top address, immediate response
    p1_req = 1; p1_we = 1; p1_addr = 14'h3FFF; p1_wdata = 16'hBEEF;
    step();
    chk("wr_strobe", mem_write_req, 1);
    chk("wr_rd_low", mem_read_req, 0);
    chk("wr_addr", mem_addr, 14'h3FFF);
    chk("wr_wdata", mem_wdata, 16'hBEEF);
    mem_resp = 1; mem_rdata = 8'h3C;
    step();
    mem_resp = 0;
    chk("wr_strobe_1cyc", mem_write_req, 0);
    chk("wr_done", p1_done, 1);
    chk("wr_err", p1_err, 0);
    chk("wr_p1_rdata_kept", p1_rdata, exp_r1);
    chk("wr_p0_rdata_kept", p0_rdata, exp_r0);
    p1_req = 0; p1_we = 0;
    step();
    chk("wr_done_low", p1_done, 0);

    // both ports requesting continuously: last winner was p1, so 0,1,0,1
    p0_req = 1; p1_req = 1; p0_addr = 14'h0AAA; p1_addr = 14'h1555;
    for (int i = 0; i < 4; i++) begin
      exp_port = i % 2;
      step();
      chk("rr_addr", mem_addr, exp_port == 0 ? 14'h0AAA : 14'h1555);
      chk("rr_strobe", mem_read_req, 1);
      mem_resp = 1; mem_rdata = 8'h10 + 8'(i);
      step();
      mem_resp = 0;
      if (exp_port == 0) exp_r0 = 8'h10 + 8'(i);
      else               exp_r1 = 8'h10 + 8'(i);
      chk("rr_p0_done", p0_done, exp_port == 0);
      chk("rr_p1_done", p1_done, exp_port == 1);
      chk("rr_p0_rdata", p0_rdata, exp_r0);
      chk("rr_p1_rdata", p1_rdata, exp_r1);
      step();
    end

    // timeout: no response ever
    p1_req = 0; p0_addr = 14'h0042;
    strobes = 0; seen_done = 0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      step();
      if (p0_done) seen_done = 1;
      else if (mem_read_req) strobes++;
    end
    chk("to_done_seen", seen_done, 1);
    chk("to_strobes", strobes, 15);
    chk("to_err", p0_err, 1);
    chk("to_rdata_kept", p0_rdata, exp_r0);
    chk("to_strobe_off", mem_read_req, 0);
    p0_req = 0;
    step();
    chk("to_err_clear", p0_err, 0);

    // response in the final timeout cycle wins
    p1_req = 1; p1_addr = 14'h0777;
    step();
    for (int c = 0; c < 14; c++) step();
    chk("edge_strobe_c15", mem_read_req, 1);
    mem_resp = 1; mem_rdata = 8'h77;
    step();
    mem_resp = 0;
    chk("edge_done", p1_done, 1);
    chk("edge_err", p1_err, 0);
    chk("edge_rdata", p1_rdata, 8'h77);
    p1_req = 0;
    step();

    // reset in REQ cycle 2 aborts without done
    p0_req = 1; p0_addr = 14'h0100;
    step();
    step();
    reset = 1;
    step();
    reset = 0; p0_req = 0;
    chk("mid_rst_strobe", mem_read_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_p0_done", p0_done, 0);
    chk("mid_rst_p0_rdata", p0_rdata, 0);
    chk("mid_rst_p1_rdata", p1_rdata, 0);
    p1_req = 1; p1_addr = 14'h2222;
    step();
    chk("post_rst_p0_done", p0_done, 0);
    chk("post_rst_addr", mem_addr, 14'h2222);
    chk("post_rst_strobe", mem_read_req, 1);
    mem_resp = 1; mem_rdata = 8'h5A;
    step();
    mem_resp = 0;
    chk("post_rst_p1_done", p1_done, 1);
    chk("post_rst_p1_rdata", p1_rdata, 8'h5A);
    p1_req = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 15: maximum cycles in REQ state awaiting mem_resp before abort (legal range 2..255).
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 p0_req / p1_req  input  1  port N requests a memory transaction; held high until pN_done.
REQ-005 p0_we / p1_we  input  1  1 = write (store), 0 = read (load); stable while pN_req high.
REQ-006 p0_addr / p1_addr  input  14  byte address into 16 KB system memory.
REQ-007 p0_wdata / p1_wdata  input  16  write data.
REQ-008 p0_rdata / p1_rdata  output  8  read data returned to port N.
REQ-009 p0_done / p1_done  output  1  one-cycle completion pulse to port N.
REQ-010 p0_err / p1_err  output  1  high with pN_done when the transaction timed out.
REQ-011 mem_read_req / mem_write_req  output  1  request strobes to the system memory model.
REQ-012 mem_addr  output  14  address to memory.
REQ-013 mem_wdata  output  16  write data to memory.
REQ-014 mem_rdata  input  8  read data from memory, valid when mem_resp high.
REQ-015 mem_resp  input  1  memory response; ends current request.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, REQ, DONE; all outputs registered.
REQ-018 IDLE: with any pN_req high, grant one port, latch its we/addr/wdata into mem_addr/mem_wdata, go to REQ; with no request, stay in IDLE.
REQ-019 Arbitration is round-robin: only one port requesting wins; both requesting wins the port not granted last; after reset port 0 has priority.
REQ-020 REQ: exactly one of mem_read_req/mem_write_req high (per latched we); mem_addr and mem_wdata stable for the whole state.
REQ-021 mem_resp sampled high in REQ: both strobes low in the next cycle, mem_rdata captured into granted pN_rdata on reads, state goes to DONE.
REQ-022 DONE: granted pN_done = 1 for exactly one cycle, pN_err per REQ-023; then IDLE unconditionally.
REQ-023 Timeout: cycle counter cleared on entering REQ and incremented each REQ cycle without mem_resp; reaching TIMEOUT_CYC drops the strobes and goes to DONE with pN_err = 1; pN_rdata is left unchanged.
REQ-024 mem_resp and mem_resp coinciding with the timeout cycle: response wins, err = 0.
REQ-025 mem_resp outside REQ is ignored; requests arriving during REQ/DONE wait for IDLE.
REQ-026 Minimum latency: req seen in IDLE cycle 0, strobe cycle 1, resp in cycle 1, done cycle 2, IDLE cycle 3.
REQ-027 pN_rdata holds its last value until the next completed read for that port; the non-granted port's outputs never change.

Reset
REQ-028 reset sampled high: state IDLE; all outputs 0 next cycle, including pN_rdata, mem_addr, mem_wdata and busy; counter 0; round-robin pointer to port 0.
REQ-029 reset mid-transaction aborts with no done pulse; the requester must re-issue.

Structure
REQ-030 Package mem_arb_pkg: state enum, ADDR_W=14, WDATA_W=16, RDATA_W=8.
REQ-031 One sub-module rr_arb2: two requests in, one-hot grant out, last-grant pointer updated on a grant-accept input.

Verification
REQ-032 p0 read addr 14'h0123, mem_resp 3 cycles after strobe with mem_rdata 8'hA5 -> p0_rdata=8'hA5, p0_done one cycle, p0_err=0, mem_read_req low after resp.
REQ-033 p1 write addr 14'h3FFF wdata 16'hBEEF, immediate resp -> mem_write_req high 1 cycle, mem_wdata=16'hBEEF, p1_done 2 cycles after grant.
REQ-034 p0 and p1 requesting continuously, each transaction 1-cycle resp -> grants alternate 0,1,0,1; no port starved.
REQ-035 No mem_resp, TIMEOUT_CYC=15 -> strobe high 15 cycles, then p0_done=1 and p0_err=1; p0_rdata unchanged.
REQ-036 reset asserted in REQ cycle 2 -> all outputs 0 next cycle, no done pulse; then p1 request alone is granted first.
